// File: rtl/dot_update_scheduler_pkg.sv
// Shared plot-area constants and FSM encoding for the dot update scheduler.
// The plot constants are also consumed by the VGA pattern generator.
package dot_update_scheduler_pkg;

  localparam logic [9:0] ORIGIN_X = 10'd170;
  localparam logic [9:0] ORIGIN_Y = 10'd141;
  localparam logic [9:0] MAX_X    = 10'd580;
  localparam logic [9:0] MAX_Y    = 10'd218;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Saturate a 9-bit offset to the largest legal offset for its axis.
  function automatic logic [9:0] clamp_offset(input logic [8:0] off, input logic [9:0] lim);
    return ({1'b0, off} > lim) ? lim : {1'b0, off};
  endfunction

endpackage

// File: rtl/dot_update_scheduler_dot_fifo.sv
// Synchronous FIFO holding committed-ready dot coordinates.
// Occupancy is kept in its own register so full/empty never depend on pointer arithmetic.
module dot_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dot_update_scheduler.sv
// Arbitrates two dot-offset requesters, clamps and buffers them, and commits
// at most one buffered coordinate per vertical-blank interval.
module dot_update_scheduler
  import dot_update_scheduler_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [8:0] req_x0,
  input  logic [8:0] req_y0,
  input  logic [8:0] req_x1,
  input  logic [8:0] req_y1,
  input  logic       vblank,
  output logic [9:0] dot_x,
  output logic [9:0] dot_y,
  output logic       dot_valid,
  output logic       frame_commit,
  output logic       clip,
  output logic [2:0] fifo_level
);

  state_e           state_q;
  logic             rr_q;
  logic             vblank_q;
  logic             clip_q;
  logic             dot_valid_q;
  logic             frame_commit_q;
  logic [9:0]       dot_x_q;
  logic [9:0]       dot_y_q;

  logic [CNT_W-1:0] count;
  logic [19:0]      fifo_head;
  logic             full;
  logic             push;
  logic             pop;
  logic             grant_sel;
  logic [8:0]       sel_x;
  logic [8:0]       sel_y;
  logic [9:0]       x_c;
  logic [9:0]       y_c;
  logic             clamp_hit;
  logic             vb_rise;

  // Space is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign full = (count == CNT_W'(DEPTH));

  always_comb begin
    req_ready = 2'b00;
    if (!full) begin
      if (&req_valid) begin
        req_ready = rr_q ? 2'b01 : 2'b10;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign push      = |(req_valid & req_ready);
  assign grant_sel = req_ready[1];
  assign sel_x     = grant_sel ? req_x1 : req_x0;
  assign sel_y     = grant_sel ? req_y1 : req_y0;
  assign x_c       = clamp_offset(sel_x, MAX_X);
  assign y_c       = clamp_offset(sel_y, MAX_Y);
  assign clamp_hit = ({1'b0, sel_x} > MAX_X) || ({1'b0, sel_y} > MAX_Y);

  assign vb_rise = vblank & ~vblank_q;
  assign pop     = (state_q == COMMIT) && (count != '0);

  dot_fifo #(
    .WIDTH (20),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  ({ORIGIN_X + x_c, ORIGIN_Y + y_c}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (count)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rr_q     <= 1'b0;
      clip_q   <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (push) begin
        rr_q <= grant_sel;
      end
      if (push && clamp_hit) begin
        clip_q <= 1'b1;
      end
    end
  end

  // The HOLD state keeps a long blanking interval from committing more than once.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      dot_x_q        <= ORIGIN_X;
      dot_y_q        <= ORIGIN_Y;
      dot_valid_q    <= 1'b0;
      frame_commit_q <= 1'b0;
    end else begin
      frame_commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vb_rise) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          if (pop) begin
            dot_x_q        <= fifo_head[19:10];
            dot_y_q        <= fifo_head[9:0];
            dot_valid_q    <= 1'b1;
            frame_commit_q <= 1'b1;
          end
          state_q <= HOLD;
        end
        HOLD: begin
          if (!vblank_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dot_x        = dot_x_q;
  assign dot_y        = dot_y_q;
  assign dot_valid    = dot_valid_q;
  assign frame_commit = frame_commit_q;
  assign clip         = clip_q;
  assign fifo_level   = 3'(count);

endmodule

// File: tb/tb_dot_update_scheduler.sv
// Directed scoreboard bench for dot_update_scheduler: a reference model predicts
// grants and committed coordinates, and a queue holds the expected commit order.
module tb_dot_update_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [8:0] req_x0 = '0;
  logic [8:0] req_y0 = '0;
  logic [8:0] req_x1 = '0;
  logic [8:0] req_y1 = '0;
  logic       vblank = 1'b0;
  logic [9:0] dot_x;
  logic [9:0] dot_y;
  logic       dot_valid;
  logic       frame_commit;
  logic       clip;
  logic [2:0] fifo_level;

  int          total = 0;
  int          bad   = 0;
  logic [19:0] sb[$];
  int          modelCount;
  int          modelRr;
  logic        modelClip;
  int          modelDotX;
  int          modelDotY;
  logic        modelValid;

  always #5 CLOCK_50 = ~CLOCK_50;

  dot_update_scheduler dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x0       (req_x0),
    .req_y0       (req_y0),
    .req_x1       (req_x1),
    .req_y1       (req_y1),
    .vblank       (vblank),
    .dot_x        (dot_x),
    .dot_y        (dot_y),
    .dot_valid    (dot_valid),
    .frame_commit (frame_commit),
    .clip         (clip),
    .fifo_level   (fifo_level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one request cycle starting at a negedge; the model decides the grant.
  task automatic applyStimulus(input logic [1:0] v, input int x0, input int y0,
                               input int x1, input int y1);
    logic [1:0] expReady;
    int         g, xs, ys, cx, cy;
    req_valid = v;
    req_x0 = 9'(x0);
    req_y0 = 9'(y0);
    req_x1 = 9'(x1);
    req_y1 = 9'(y1);
    #1;
    expReady = 2'b00;
    if (modelCount < 4) begin
      if (v == 2'b11) expReady = (modelRr == 1) ? 2'b01 : 2'b10;
      else            expReady = v;
    end
    checkOutput("req_ready", req_ready, expReady);
    if (expReady != 2'b00) begin
      g  = expReady[1] ? 1 : 0;
      xs = g ? x1 : x0;
      ys = g ? y1 : y0;
      cx = (xs > 580) ? 580 : xs;
      cy = (ys > 218) ? 218 : ys;
      if (xs > 580 || ys > 218) modelClip = 1'b1;
      sb.push_back({10'(170 + cx), 10'(141 + cy)});
      modelRr = g;
      modelCount++;
    end
    @(negedge CLOCK_50);
    req_valid = 2'b00;
    checkOutput("fifo_level", fifo_level, modelCount);
    checkOutput("clip", clip, modelClip);
  endtask

  // Raises vblank for 'hold' cycles and counts commit pulses over the whole interval.
  task automatic vblankPulse(input int hold);
    int          commits = 0;
    int          firstAt = -1;
    logic        expCommit;
    logic [19:0] e;
    expCommit = (sb.size() > 0);
    vblank = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge CLOCK_50);
      if (frame_commit === 1'b1) begin
        commits++;
        if (firstAt < 0) firstAt = i;
      end
    end
    vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      if (frame_commit === 1'b1) commits++;
    end
    if (expCommit) begin
      e = sb.pop_front();
      modelDotX  = int'(e[19:10]);
      modelDotY  = int'(e[9:0]);
      modelValid = 1'b1;
      modelCount--;
      checkOutput("commit_latency", firstAt, 2);
    end
    checkOutput("commits", commits, expCommit ? 1 : 0);
    checkOutput("dot_x", dot_x, modelDotX);
    checkOutput("dot_y", dot_y, modelDotY);
    checkOutput("dot_valid", dot_valid, modelValid);
    checkOutput("fifo_level_after_vb", fifo_level, modelCount);
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    vblank    = 1'b0;
    #2;
    sb.delete();
    modelCount = 0;
    modelRr    = 0;
    modelClip  = 1'b0;
    modelDotX  = 170;
    modelDotY  = 141;
    modelValid = 1'b0;
    checkOutput("rst_dot_x", dot_x, 170);
    checkOutput("rst_dot_y", dot_y, 141);
    checkOutput("rst_dot_valid", dot_valid, 0);
    checkOutput("rst_frame_commit", frame_commit, 0);
    checkOutput("rst_clip", clip, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_state", dut.state_q, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  initial begin
    logic [19:0] e;
    @(negedge CLOCK_50);
    doReset();

    // Blanking with nothing queued leaves the dot at the origin.
    repeat (3) vblankPulse(4);

    // Single request from requester 0.
    applyStimulus(2'b01, 10, 20, 0, 0);
    vblankPulse(4);

    // Out-of-range offsets through requester 1; clip stays sticky afterwards.
    applyStimulus(2'b10, 0, 0, 511, 300);
    vblankPulse(4);
    applyStimulus(2'b10, 0, 0, 5, 6);
    vblankPulse(4);
    checkOutput("clip_sticky", clip, 1);

    // Both requesters active: alternate grants until the FIFO fills, then stall.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, 30 + i, 40 + i, 100 + i, 110 + i);
    end
    checkOutput("full_level", fifo_level, 4);
    repeat (4) vblankPulse(4);

    // A long blanking interval commits only once; further intervals drain in order.
    applyStimulus(2'b01, 1, 2, 0, 0);
    applyStimulus(2'b01, 3, 4, 0, 0);
    applyStimulus(2'b01, 5, 6, 0, 0);
    vblankPulse(1000);
    vblankPulse(4);
    vblankPulse(4);
    vblankPulse(4);

    // Reset while holding in a blanking interval with two entries still queued.
    applyStimulus(2'b01, 7, 8, 0, 0);
    applyStimulus(2'b01, 9, 10, 0, 0);
    applyStimulus(2'b01, 11, 12, 0, 0);
    vblank = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    e = sb.pop_front();
    modelCount--;
    checkOutput("pre_rst_level", fifo_level, modelCount);
    checkOutput("pre_rst_state", dut.state_q, 2);
    checkOutput("pre_rst_dot_x", dot_x, int'(e[19:10]));
    doReset();
    applyStimulus(2'b10, 0, 0, 50, 60);
    vblankPulse(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
